// File: rtl/vending_param.sv
// vending_param: parametrised vending controller with per-product stock,
// sold-out flags, cancel/refund and credit-overflow coin rejection.
// Change is paid one coin per cycle in quarters, dimes and nickels.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous reset, active-low
//   s5, s10, s25, s100       coin-inserted pulses (one cycle each)
//   sel[N_PROD]              product selection pulses
//   cancel                   refund request pulse
//   m[MW]                    current credit (registered)
//   c[MW]                    change remaining to pay (registered)
//   relq, reld, reln         quarter/dime/nickel release pulses
//   rel[N_PROD]              product release pulses
//   coin_reject              coin refused this cycle (combinational)
//   sold_out[N_PROD]         level flag, stock of product i is zero
//   qcollect, qrelease,
//   qinitc, qchange          one-hot state indicators
module vending_param #(
  parameter int unsigned          N_PROD     = 4,
  parameter int unsigned          MW         = 8,
  parameter logic [N_PROD*MW-1:0] PRICES     = {8'd100, 8'd75, 8'd65, 8'd50},
  parameter int unsigned          MAX_CREDIT = 200,
  parameter int unsigned          STOCK_W    = 4,
  parameter int unsigned          INIT_STOCK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s5,
  input  logic              s10,
  input  logic              s25,
  input  logic              s100,
  input  logic [N_PROD-1:0] sel,
  input  logic              cancel,
  output logic [MW-1:0]     m,
  output logic [MW-1:0]     c,
  output logic              relq,
  output logic              reld,
  output logic              reln,
  output logic [N_PROD-1:0] rel,
  output logic              coin_reject,
  output logic [N_PROD-1:0] sold_out,
  output logic              qcollect,
  output logic              qrelease,
  output logic              qinitc,
  output logic              qchange
);

  localparam int unsigned IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int unsigned SW    = MW + 1;

  localparam logic [MW-1:0] V_Q = MW'(25);
  localparam logic [MW-1:0] V_D = MW'(10);
  localparam logic [MW-1:0] V_N = MW'(5);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_RELEASE = 2'd1,
    S_INITC   = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MW-1:0]       r_m;
  logic [MW-1:0]       w_m_nxt;
  logic [MW-1:0]       r_c;
  logic [MW-1:0]       w_c_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [STOCK_W-1:0]  r_stock [N_PROD];
  logic                w_stock_dec;

  logic                w_coin_vld;
  logic [SW-1:0]       w_coin;
  logic [SW-1:0]       w_sum;
  logic                w_fits;
  logic                w_sel_one;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_buy;
  logic                w_cancel;

  function automatic logic [MW-1:0] price_of(input logic [IDX_W-1:0] idx);
    return PRICES[int'(idx)*MW +: MW];
  endfunction

  // Highest asserted denomination wins; lower simultaneous lines are dropped.
  always_comb begin
    w_coin     = '0;
    w_coin_vld = 1'b1;
    if (s100)      w_coin = SW'(100);
    else if (s25)  w_coin = SW'(25);
    else if (s10)  w_coin = SW'(10);
    else if (s5)   w_coin = SW'(5);
    else           w_coin_vld = 1'b0;
  end

  // Credit sum kept one bit wider so an overflowing coin is caught, not wrapped.
  assign w_sum  = {1'b0, r_m} + w_coin;
  assign w_fits = (w_sum <= SW'(MAX_CREDIT));

  // Selection decode: only a single pressed button can be honoured.
  always_comb begin
    w_sel_one = $onehot(sel);
    w_sel_idx = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_buy    = w_sel_one && (r_stock[w_sel_idx] != '0) &&
                    (r_m >= price_of(w_sel_idx));
  assign w_cancel = cancel && (r_m != '0);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_COLLECT;
      r_m     <= '0;
      r_c     <= '0;
      r_idx   <= '0;
      for (int i = 0; i < N_PROD; i++) begin
        r_stock[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
      r_c     <= w_c_nxt;
      r_idx   <= w_idx_nxt;
      if (w_stock_dec) begin
        r_stock[r_idx] <= r_stock[r_idx] - STOCK_W'(1);
      end
    end
  end

  // Next-state, datapath updates and pulse outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_c_nxt     = r_c;
    w_idx_nxt   = r_idx;
    w_stock_dec = 1'b0;
    rel         = '0;
    relq        = 1'b0;
    reld        = 1'b0;
    reln        = 1'b0;
    coin_reject = 1'b0;

    case (r_state)
      S_COLLECT: begin
        if (w_cancel) begin
          // Refund outranks any selection; a coin this cycle is refused.
          w_state_nxt = S_INITC;
          coin_reject = w_coin_vld;
        end else if (w_buy) begin
          w_idx_nxt   = w_sel_idx;
          w_state_nxt = S_RELEASE;
          coin_reject = w_coin_vld;
        end else if (w_coin_vld) begin
          if (w_fits) w_m_nxt = w_sum[MW-1:0];
          else        coin_reject = 1'b1;
        end
      end

      S_RELEASE: begin
        rel         = N_PROD'(1) << r_idx;
        w_m_nxt     = r_m - price_of(r_idx);
        w_stock_dec = 1'b1;
        w_state_nxt = S_INITC;
        coin_reject = w_coin_vld;
      end

      S_INITC: begin
        w_c_nxt     = r_m;
        w_m_nxt     = '0;
        w_state_nxt = S_CHANGE;
        coin_reject = w_coin_vld;
      end

      S_CHANGE: begin
        coin_reject = w_coin_vld;
        // Greedy payout, largest coin first, one coin per cycle.
        if (r_c >= V_Q) begin
          relq    = 1'b1;
          w_c_nxt = r_c - V_Q;
        end else if (r_c >= V_D) begin
          reld    = 1'b1;
          w_c_nxt = r_c - V_D;
        end else if (r_c >= V_N) begin
          reln    = 1'b1;
          w_c_nxt = r_c - V_N;
        end else begin
          w_c_nxt     = '0;
          w_state_nxt = S_COLLECT;
        end
      end

      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  assign m = r_m;
  assign c = r_c;

  assign qcollect = (r_state == S_COLLECT);
  assign qrelease = (r_state == S_RELEASE);
  assign qinitc   = (r_state == S_INITC);
  assign qchange  = (r_state == S_CHANGE);

  // Sold-out flags track the live stock counters.
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_PROD; i++) begin
      sold_out[i] = (r_stock[i] == '0);
    end
  end

endmodule

// File: tb/tb_vending_param.sv
// Testbench for vending_param: table of per-cycle vectors checked through a
// scoreboard queue, plus a hand-written purchase sequence with a cycle budget.
module tb_vending_param;

  localparam logic [3:0] COL = 4'b0001;
  localparam logic [3:0] REL = 4'b0010;
  localparam logic [3:0] INI = 4'b0100;
  localparam logic [3:0] CHG = 4'b1000;

  localparam logic [3:0] S100 = 4'b1000;
  localparam logic [3:0] S25  = 4'b0100;
  localparam logic [3:0] S10  = 4'b0010;
  localparam logic [3:0] S5   = 4'b0001;

  localparam logic [2:0] PQ = 3'b100;
  localparam logic [2:0] PD = 3'b010;

  logic       clk = 1'b0;
  logic       reset;
  logic       s5, s10, s25, s100;
  logic [3:0] sel;
  logic       cancel;
  logic [7:0] m, c;
  logic       relq, reld, reln;
  logic [3:0] rel;
  logic       coin_reject;
  logic [3:0] sold_out;
  logic       qcollect, qrelease, qinitc, qchange;

  always #5 clk = ~clk;

  vending_param #(
    .N_PROD(4), .MW(8), .PRICES({8'd100, 8'd75, 8'd65, 8'd50}),
    .MAX_CREDIT(200), .STOCK_W(4), .INIT_STOCK(3)
  ) dut (
    .clk(clk), .reset(reset),
    .s5(s5), .s10(s10), .s25(s25), .s100(s100),
    .sel(sel), .cancel(cancel),
    .m(m), .c(c),
    .relq(relq), .reld(reld), .reln(reln),
    .rel(rel), .coin_reject(coin_reject), .sold_out(sold_out),
    .qcollect(qcollect), .qrelease(qrelease), .qinitc(qinitc), .qchange(qchange)
  );

  typedef struct {
    logic       rst;
    logic [3:0] coins;
    logic [3:0] sel;
    logic       cancel;
    logic [7:0] m;
    logic [7:0] c;
    logic [3:0] rel;
    logic [2:0] pay;
    logic       rej;
    logic [3:0] st;
    logic [3:0] sold;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic rst, input logic [3:0] coins,
                              input logic [3:0] s, input logic can,
                              input int em, input int ec, input logic [3:0] erel,
                              input logic [2:0] epay, input logic erej,
                              input logic [3:0] est, input logic [3:0] esold);
    vec_t v;
    v.rst = rst; v.coins = coins; v.sel = s; v.cancel = can;
    v.m = 8'(em); v.c = 8'(ec); v.rel = erel; v.pay = epay;
    v.rej = erej; v.st = est; v.sold = esold;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  initial begin
    logic [3:0] so;
    vec_t       v;
    vec_t       e;
    int         nq, nd, nn;
    logic       done;

    reset = 1'b0; {s100, s25, s10, s5} = 4'b0; sel = '0; cancel = 1'b0;

    // Reset state
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    // s100 then buy product 1 (65): change 35 = quarter + dime
    add(1, S100, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    add(1, 0, 4'b0010, 0, 100, 0, 0, 0, 0, COL, 0);
    add(1, 0, 0, 0, 100, 0, 4'b0010, 0, 0, REL, 0);
    add(1, 0, 0, 0, 35, 0, 0, 0, 0, INI, 0);
    add(1, 0, 0, 0, 0, 35, 0, PQ, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 10, 0, PD, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    // 150 credit, buy product 3 (100): change 50
    add(1, S10, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    add(1, S10, 0, 0, 10, 0, 0, 0, 0, COL, 0);
    add(1, S5, 0, 0, 20, 0, 0, 0, 0, COL, 0);
    add(1, S25, 0, 0, 25, 0, 0, 0, 0, COL, 0);
    add(1, S100, 0, 0, 50, 0, 0, 0, 0, COL, 0);
    add(1, 0, 4'b1000, 0, 150, 0, 0, 0, 0, COL, 0);
    add(1, 0, 0, 0, 150, 0, 4'b1000, 0, 0, REL, 0);
    add(1, 0, 0, 0, 50, 0, 0, 0, 0, INI, 0);
    add(1, 0, 0, 0, 0, 50, 0, PQ, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 25, 0, PQ, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    // Fill to MAX_CREDIT, overflow coin rejected, cancel outranks sel
    add(1, S100, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    add(1, S100, 0, 0, 100, 0, 0, 0, 0, COL, 0);
    add(1, S5, 0, 0, 200, 0, 0, 0, 1, COL, 0);
    add(1, 0, 0, 0, 200, 0, 0, 0, 0, COL, 0);
    add(1, 0, 4'b0001, 1, 200, 0, 0, 0, 0, COL, 0);
    add(1, S5, 0, 0, 200, 0, 0, 0, 1, INI, 0);
    for (int k = 0; k < 8; k++) add(1, 0, 0, 0, 0, 200 - 25*k, 0, PQ, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, CHG, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 0);
    // Deplete product 0 (price 50) in three exact-change rounds
    for (int r = 0; r < 3; r++) begin
      so = (r == 2) ? 4'b0001 : 4'b0000;
      add(1, S25, 0, 0, 0, 0, 0, 0, 0, COL, 0);
      add(1, S25, 0, 0, 25, 0, 0, 0, 0, COL, 0);
      add(1, 0, 4'b0001, 0, 50, 0, 0, 0, 0, COL, 0);
      add(1, 0, 0, 0, 50, 0, 4'b0001, 0, 0, REL, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, INI, so);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, CHG, so);
    end
    // Sold-out selection ignored, then cancel refunds 50
    add(1, S25, 0, 0, 0, 0, 0, 0, 0, COL, 4'b0001);
    add(1, S25, 0, 0, 25, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 4'b0001, 0, 50, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 0, 50, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 1, 50, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 0, 50, 0, 0, 0, 0, INI, 4'b0001);
    add(1, 0, 0, 0, 0, 50, 0, PQ, 0, CHG, 4'b0001);
    add(1, 0, 0, 0, 0, 25, 0, PQ, 0, CHG, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, CHG, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 4'b0001);
    // Cancel with zero credit does nothing
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 4'b0001);
    // Insufficient credit, two buttons, simultaneous coins
    add(1, S25, 0, 0, 0, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 4'b0010, 0, 25, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 0, 25, 0, 0, 0, 0, COL, 4'b0001);
    add(1, S100, 0, 0, 25, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 4'b0011, 0, 125, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 0, 125, 0, 0, 0, 0, COL, 4'b0001);
    add(1, S25 | S10, 0, 0, 125, 0, 0, 0, 0, COL, 4'b0001);
    add(1, 0, 0, 0, 150, 0, 0, 0, 0, COL, 4'b0001);
    // Coin arriving with a valid purchase is rejected; buy product 2 (75)
    add(1, S5, 4'b0100, 0, 150, 0, 0, 0, 1, COL, 4'b0001);
    add(1, 0, 0, 0, 150, 0, 4'b0100, 0, 0, REL, 4'b0001);
    add(1, 0, 0, 0, 75, 0, 0, 0, 0, INI, 4'b0001);
    add(1, 0, 0, 0, 0, 75, 0, PQ, 0, CHG, 4'b0001);
    add(1, 0, 0, 0, 0, 50, 0, PQ, 0, CHG, 4'b0001);
    // Reset asserted mid-payout at c=25, takes effect at the next edge
    add(0, 0, 0, 0, 0, 25, 0, PQ, 0, CHG, 4'b0001);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 4'b0000);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, COL, 4'b0000);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(posedge clk);
      #1;
      reset = v.rst; {s100, s25, s10, s5} = v.coins; sel = v.sel; cancel = v.cancel;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk("m", i, 32'(m), 32'(e.m));
      chk("c", i, 32'(c), 32'(e.c));
      chk("rel", i, 32'(rel), 32'(e.rel));
      chk("pay_qdn", i, 32'({relq, reld, reln}), 32'(e.pay));
      chk("coin_reject", i, 32'(coin_reject), 32'(e.rej));
      chk("state", i, 32'({qchange, qinitc, qrelease, qcollect}), 32'(e.st));
      chk("sold_out", i, 32'(sold_out), 32'(e.sold));
    end

    // Hand sequence: 125 credit, buy product 2 (75), expect two quarters
    @(posedge clk); #1; reset = 1'b1; {s100, s25, s10, s5} = S100; sel = '0; cancel = 1'b0;
    @(posedge clk); #1; {s100, s25, s10, s5} = S25;
    @(posedge clk); #1; {s100, s25, s10, s5} = 4'b0; sel = 4'b0100;
    @(negedge clk);
    chk("hs_credit", 0, 32'(m), 32'd125);
    @(posedge clk); #1; sel = '0;
    nq = 0; nd = 0; nn = 0; done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      chk("hs_onehot", cyc, 32'($onehot({qchange, qinitc, qrelease, qcollect})), 32'd1);
      if (relq) nq++;
      if (reld) nd++;
      if (reln) nn++;
      if (qcollect) done = 1'b1;
    end
    chk("hs_reached_collect", 0, 32'(done), 32'd1);
    chk("hs_quarters", 0, 32'(nq), 32'd2);
    chk("hs_dimes", 0, 32'(nd), 32'd0);
    chk("hs_nickels", 0, 32'(nn), 32'd0);
    chk("hs_m_after", 0, 32'(m), 32'd0);
    chk("hs_sold_out", 0, 32'(sold_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
